// File: rtl/serializer_piso_framed.sv
// Parallel-in/serial-out framer: accepts a word over valid/ready and emits an
// optional start bit followed by WIDTH data bits MSB-first, then GAP_CYCLES idle cycles.
module serializer_piso_framed #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned START_BIT  = 1,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             serial_en,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;

  logic serial_out_q, serial_out_d;
  logic serial_en_q, serial_en_d;
  logic busy_q, busy_d;
  logic frame_done_q, frame_done_d;
  logic load_ready_q, load_ready_d;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (load_valid && load_ready_q) begin
          shreg_d   = data_in;
          bit_cnt_d = '0;
          state_d   = (START_BIT != 0) ? START : DATA;
        end
      end
      START: state_d = DATA;
      DATA: begin
        shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + BW'(1);
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          if (GAP_CYCLES > 0) begin
            state_d   = GAP;
            gap_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q + GW'(1);
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_comb begin
    serial_out_d = (state_d == START) || ((state_d == DATA) && shreg_d[WIDTH-1]);
    serial_en_d  = (state_d == START) || (state_d == DATA);
    busy_d       = (state_d != IDLE);
    load_ready_d = (state_d == IDLE);
    frame_done_d = (state_d == DATA) && (bit_cnt_d == BIT_LAST);
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      serial_out_q <= 1'b0;
      serial_en_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      load_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      serial_out_q <= serial_out_d;
      serial_en_q  <= serial_en_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      load_ready_q <= load_ready_d;
    end
  end

  assign serial_out = serial_out_q;
  assign serial_en  = serial_en_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign load_ready = load_ready_q;

endmodule

// File: tb/tb_serializer_piso_framed.sv
// Scoreboard bench for serializer_piso_framed: default instance plus an
// 8-bit / no-start / no-gap instance.
module tb_serializer_piso_framed;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic clk = 1'b0;
  logic clear_n;

  logic [3:0] data_in;
  logic       load_valid, load_ready, serial_out, serial_en, busy, frame_done;

  logic [7:0] data8;
  logic       valid8, ready8, sout8, sen8, busy8, done8;

  exp_t q4[$];
  exp_t q8[$];
  int   acc4[$];
  int   acc8[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serializer_piso_framed #(.WIDTH(4), .START_BIT(1), .GAP_CYCLES(1)) dut (
    .clk(clk), .clear_n(clear_n), .data_in(data_in), .load_valid(load_valid),
    .load_ready(load_ready), .serial_out(serial_out), .serial_en(serial_en),
    .busy(busy), .frame_done(frame_done)
  );

  serializer_piso_framed #(.WIDTH(8), .START_BIT(0), .GAP_CYCLES(0)) dut8 (
    .clk(clk), .clear_n(clear_n), .data_in(data8), .load_valid(valid8),
    .load_ready(ready8), .serial_out(sout8), .serial_en(sen8),
    .busy(busy8), .frame_done(done8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic push4(input logic [3:0] w);
    exp_t e;
    e.b = 1'b1; e.last = 1'b0;
    q4.push_back(e);
    for (int i = 3; i >= 0; i--) begin
      e.b = w[i]; e.last = (i == 0);
      q4.push_back(e);
    end
  endtask

  task automatic push8(input logic [7:0] w);
    exp_t e;
    for (int i = 7; i >= 0; i--) begin
      e.b = w[i]; e.last = (i == 0);
      q8.push_back(e);
    end
  endtask

  // Monitors: every frame bit is popped and compared; outside frames the line must be quiet.
  always @(negedge clk) begin
    exp_t e;
    if (serial_en) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_bit4: got bit %0b expected no frame bit (t=%0t)", serial_out, $time);
      end else begin
        e = q4.pop_front();
        check("bit4", 32'(serial_out), 32'(e.b));
        check("frame_done4", 32'(frame_done), 32'(e.last));
      end
    end else begin
      check("quiet4", {30'd0, serial_out, frame_done}, 32'd0);
    end
    if (load_valid && load_ready) acc4.push_back(cyc + 1);
  end

  always @(negedge clk) begin
    exp_t e;
    if (sen8) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_bit8: got bit %0b expected no frame bit (t=%0t)", sout8, $time);
      end else begin
        e = q8.pop_front();
        check("bit8", 32'(sout8), 32'(e.b));
        check("frame_done8", 32'(done8), 32'(e.last));
      end
    end else begin
      check("quiet8", {30'd0, sout8, done8}, 32'd0);
    end
    if (valid8 && ready8) acc8.push_back(cyc + 1);
  end

  task automatic wait_idle4();
    int n = 0;
    while (load_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("idle_reached4", 32'(load_ready), 32'd1);
  endtask

  task automatic wait_idle8();
    int n = 0;
    while (ready8 !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("idle_reached8", 32'(ready8), 32'd1);
  endtask

  task automatic send4(input logic [3:0] w);
    data_in    = w;
    load_valid = 1'b1;
    push4(w);
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  task automatic check_quiet_outputs(input string name);
    check({name, "_serial_out"}, 32'(serial_out), 32'd0);
    check({name, "_serial_en"},  32'(serial_en),  32'd0);
    check({name, "_busy"},       32'(busy),       32'd0);
    check({name, "_frame_done"}, 32'(frame_done), 32'd0);
    check({name, "_load_ready"}, 32'(load_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_n    = 1'b0;
    load_valid = 1'b1;
    data_in    = 4'hF;
    valid8     = 1'b0;
    data8      = 8'h00;

    // 1: reset holds everything quiet even with load_valid asserted
    repeat (3) begin
      @(posedge clk); #1;
      check_quiet_outputs("reset");
    end
    push4(4'hF);
    clear_n = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    check("reset_release_first_bit", 32'(serial_en), 32'd1);
    wait_idle4();

    // 2: single frame 1011, load_ready low for 6 cycles after acceptance
    @(posedge clk); #1;
    send4(4'b1011);
    check("latency_en", 32'(serial_en), 32'd1);
    check("latency_start", 32'(serial_out), 32'd1);
    for (int k = 0; k < 6; k++) begin
      check("ready_low_busy", {30'd0, load_ready, busy}, 32'd1);
      @(posedge clk); #1;
    end
    check("ready_return", {30'd0, load_ready, busy}, 32'd2);

    // 3: back-to-back frames with load_valid held high
    acc4.delete();
    push4(4'b1100);
    push4(4'b0011);
    data_in    = 4'b1100;
    load_valid = 1'b1;
    @(posedge clk); #1;
    data_in = 4'b0011;
    repeat (7) @(posedge clk);
    #1;
    load_valid = 1'b0;
    wait_idle4();
    check("b2b_accept_count", 32'(acc4.size()), 32'd2);
    if (acc4.size() == 2) check("b2b_period", 32'(acc4[1] - acc4[0]), 32'd7);

    // 4: load_valid pulses and data_in changes while busy are ignored
    @(posedge clk); #1;
    send4(4'b1001);
    for (int k = 0; k < 4; k++) begin
      load_valid = 1'b1;
      data_in    = (k[0]) ? 4'b0101 : 4'b1110;
      check("ready_low_while_busy", 32'(load_ready), 32'd0);
      @(posedge clk); #1;
      load_valid = 1'b0;
    end
    wait_idle4();

    // 5: abort after two data bits of 1010, then a clean 0110
    @(posedge clk); #1;
    send4(4'b1010);
    repeat (3) @(posedge clk);
    #1;
    clear_n = 1'b0;
    #1;
    check_quiet_outputs("abort");
    q4.delete();
    @(posedge clk); #1;
    clear_n = 1'b1;
    @(posedge clk); #1;
    send4(4'b0110);
    wait_idle4();
    check("q4_empty", 32'(q4.size()), 32'd0);

    // 6: 8-bit, no start bit, no gap: A5 then 3C at a 9-cycle period
    acc8.delete();
    push8(8'hA5);
    push8(8'h3C);
    data8  = 8'hA5;
    valid8 = 1'b1;
    @(posedge clk); #1;
    check("w8_latency_en", 32'(sen8), 32'd1);
    check("w8_first_bit", 32'(sout8), 32'd1);
    data8 = 8'h3C;
    repeat (9) @(posedge clk);
    #1;
    valid8 = 1'b0;
    wait_idle8();
    check("w8_accept_count", 32'(acc8.size()), 32'd2);
    if (acc8.size() == 2) check("w8_period", 32'(acc8[1] - acc8[0]), 32'd9);
    check("q8_empty", 32'(q8.size()), 32'd0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
